// File: rtl/tug_war_pkg.sv
// Shared types and constants for the tug-of-war match core.
package tug_war_pkg;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        ROUND_END = 2'd1,
        MATCH_END = 2'd2
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_L    = 2'b10;
    localparam logic [1:0] WIN_R    = 2'b01;

    // Fibonacci LFSR x^10 + x^7 + 1: feedback from bits 9 and 6
    localparam int         LFSR_W    = 10;
    localparam logic [9:0] LFSR_SEED = 10'h001;
    localparam logic [9:0] LFSR_TAPS = 10'h240;

endpackage

// File: rtl/key_press_sync.sv
// Synchroniser plus falling-edge detect for one active-low push button.
module key_press_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Preset to released so a key held through reset never counts as a press
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign press = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/tug_war_match.sv
// Multi-round tug-of-war match core: playfield, scores, round pause, match latch.
// Optional CPU_PLAYER_EN replaces the right key with an LFSR-driven CPU player.
module tug_war_match
    import tug_war_pkg::*;
#(
    parameter int NUM_LEDS    = 9,
    parameter int WIN_ROUNDS  = 7,
    parameter int ROUND_PAUSE = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_l,
    input  logic                key_r,
    input  logic [3:0]          cpu_level,
    output logic [NUM_LEDS-1:0] leds,
    output logic [3:0]          score_l,
    output logic [3:0]          score_r,
    output logic                round_over,
    output logic                match_over,
    output logic [1:0]          winner
);

    localparam int PW  = $clog2(NUM_LEDS);
    localparam int PCW = $clog2(ROUND_PAUSE + 1);

    localparam logic [PW-1:0]       POS_C      = PW'((NUM_LEDS - 1) / 2);
    localparam logic [PW-1:0]       POS_MAX    = PW'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] LED_ONE    = NUM_LEDS'(1);
    localparam logic [NUM_LEDS-1:0] LED_C      = LED_ONE << POS_C;
    localparam logic [3:0]          SCORE_LAST = 4'(WIN_ROUNDS - 1);
    localparam logic [PCW-1:0]      PAUSE_LOAD = PCW'(ROUND_PAUSE - 1);

    state_t         state;
    logic [PW-1:0]  pos;
    logic [PW-1:0]  pos_up;
    logic [PW-1:0]  pos_dn;
    logic [PCW-1:0] pause_cnt;
    logic           press_l;
    logic           press_r;

    key_press_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_l (
        .clk   (clk),
        .rst   (rst),
        .key   (key_l),
        .press (press_l)
    );

`ifdef CPU_PLAYER_EN
    logic [LFSR_W-1:0] lfsr;
    logic              unused_key_r;

    always_ff @(posedge clk) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    end

    assign press_r      = (lfsr < {cpu_level, 6'b0});
    assign unused_key_r = key_r;
`else
    logic unused_cpu_level;

    key_press_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_r (
        .clk   (clk),
        .rst   (rst),
        .key   (key_r),
        .press (press_r)
    );

    assign unused_cpu_level = ^cpu_level;
`endif

    assign pos_up = pos + PW'(1);
    assign pos_dn = pos - PW'(1);

    // leds is decoded alongside every pos/state change so it stays a pure register
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PLAY;
            pos        <= POS_C;
            leds       <= LED_C;
            score_l    <= 4'd0;
            score_r    <= 4'd0;
            pause_cnt  <= '0;
            round_over <= 1'b0;
            match_over <= 1'b0;
            winner     <= WIN_NONE;
        end else begin
            case (state)
                PLAY: begin
                    if (press_l && !press_r) begin
                        if (pos == POS_MAX) begin
                            score_l   <= score_l + 4'd1;
                            pause_cnt <= PAUSE_LOAD;
                            if (score_l == SCORE_LAST) begin
                                state      <= MATCH_END;
                                leds       <= '1;
                                match_over <= 1'b1;
                                winner     <= WIN_L;
                            end else begin
                                state      <= ROUND_END;
                                leds       <= '0;
                                round_over <= 1'b1;
                            end
                        end else begin
                            pos  <= pos_up;
                            leds <= LED_ONE << pos_up;
                        end
                    end else if (press_r && !press_l) begin
                        if (pos == '0) begin
                            score_r   <= score_r + 4'd1;
                            pause_cnt <= PAUSE_LOAD;
                            if (score_r == SCORE_LAST) begin
                                state      <= MATCH_END;
                                leds       <= '1;
                                match_over <= 1'b1;
                                winner     <= WIN_R;
                            end else begin
                                state      <= ROUND_END;
                                leds       <= '0;
                                round_over <= 1'b1;
                            end
                        end else begin
                            pos  <= pos_dn;
                            leds <= LED_ONE << pos_dn;
                        end
                    end
                end
                ROUND_END: begin
                    if (pause_cnt == '0) begin
                        state      <= PLAY;
                        pos        <= POS_C;
                        leds       <= LED_C;
                        round_over <= 1'b0;
                    end else begin
                        pause_cnt <= pause_cnt - PCW'(1);
                    end
                end
                MATCH_END: ;
                default: state <= PLAY;
            endcase
        end
    end

endmodule

// File: tb/tb_tug_war_match.sv
// Directed self-checking bench for tug_war_match (NUM_LEDS=9, WIN_ROUNDS=3).
module tb_tug_war_match;

    localparam int NUM_LEDS    = 9;
    localparam int WIN_ROUNDS  = 3;
    localparam int ROUND_PAUSE = 4;
    localparam int SYNC_STAGES = 2;

    localparam logic [8:0] LED_CENTRE = 9'b000010000;

    logic                clk;
    logic                rst;
    logic                key_l;
    logic                key_r;
    logic [3:0]          cpu_level;
    logic [NUM_LEDS-1:0] leds;
    logic [3:0]          score_l;
    logic [3:0]          score_r;
    logic                round_over;
    logic                match_over;
    logic [1:0]          winner;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    tug_war_match #(
        .NUM_LEDS    (NUM_LEDS),
        .WIN_ROUNDS  (WIN_ROUNDS),
        .ROUND_PAUSE (ROUND_PAUSE),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_l      (key_l),
        .key_r      (key_r),
        .cpu_level  (cpu_level),
        .leds       (leds),
        .score_l    (score_l),
        .score_r    (score_r),
        .round_over (round_over),
        .match_over (match_over),
        .winner     (winner)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // drivers: step one edge and settle, inputs change 1 time unit after posedge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Key(s) low 2 cycles then high 2 cycles; the move lands on the 3rd edge
    task automatic pulse(input bit l, input bit r);
        key_l = l ? 1'b0 : 1'b1;
        key_r = r ? 1'b0 : 1'b1;
        tick();
        tick();
        key_l = 1'b1;
        key_r = 1'b1;
        tick();
        tick();
    endtask

    task automatic win_round(input bit left);
        for (int i = 0; i < 5; i++) pulse(left, !left);
        repeat (4) tick();
    endtask

    task automatic check_state(input string tag, input logic [8:0] exp_leds,
                               input logic [3:0] exp_sl, input logic [3:0] exp_sr);
        check({tag, "_leds"}, 32'(leds), 32'(exp_leds));
        check({tag, "_score_l"}, 32'(score_l), 32'(exp_sl));
        check({tag, "_score_r"}, 32'(score_r), 32'(exp_sr));
    endtask

    initial begin
        rst       = 1'b1;
        key_l     = 1'b1;
        key_r     = 1'b1;
        cpu_level = 4'd0;
        #1;

        // 1: reset state
        do_reset();
        check_state("reset", LED_CENTRE, 4'd0, 4'd0);
        check("reset_round_over", 32'(round_over), 32'd0);
        check("reset_match_over", 32'(match_over), 32'd0);
        check("reset_winner", 32'(winner), 32'd0);

        // 2: left walks to the edge, then wins the round
        for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0);
        check("left_edge_leds", 32'(leds), 32'h100);
        key_l = 1'b0;
        tick();
        tick();
        check("pre_win_leds", 32'(leds), 32'h100);
        key_l = 1'b1;
        for (int i = 0; i < ROUND_PAUSE; i++) exp_q.push_back(9'd0);
        exp_q.push_back(LED_CENTRE);
        for (int i = 0; i < ROUND_PAUSE + 1; i++) begin
            logic [8:0] e;
            tick();
            e = exp_q.pop_front();
            check($sformatf("pause_leds_%0d", i), 32'(leds), 32'(e));
            check($sformatf("pause_round_over_%0d", i), 32'(round_over),
                  (i < ROUND_PAUSE) ? 32'd1 : 32'd0);
            if (i == 0) check("win_score_l", 32'(score_l), 32'd1);
        end

        // 3: simultaneous presses are ignored
        pulse(1'b1, 1'b1);
        tick();
        check_state("simul", LED_CENTRE, 4'd1, 4'd0);

        // 4: held right key moves exactly once, three edges after the drop
        key_r = 1'b0;
        tick();
        tick();
        check("hold_edge2_leds", 32'(leds), 32'(LED_CENTRE));
        tick();
        check("hold_edge3_leds", 32'(leds), 32'h008);
        repeat (17) tick();
        key_r = 1'b1;
        repeat (4) tick();
        check_state("hold_after", 9'b000001000, 4'd1, 4'd0);

        // 5: right takes the match
        do_reset();
        pulse(1'b0, 1'b1);
        check("r1_first_move", 32'(leds), 32'h008);
        for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1);
        check("r1_round_over", 32'(round_over), 32'd1);
        check("r1_score_r", 32'(score_r), 32'd1);
        repeat (4) tick();
        check("r1_back_centre", 32'(leds), 32'(LED_CENTRE));
        win_round(1'b0);
        check("r2_score_r", 32'(score_r), 32'd2);
        for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1);
        check_state("match", 9'h1FF, 4'd0, 4'd3);
        check("match_over", 32'(match_over), 32'd1);
        check("match_winner", 32'(winner), 32'b01);
        check("match_round_over", 32'(round_over), 32'd0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        check_state("match_frozen", 9'h1FF, 4'd0, 4'd3);
        check("match_frozen_winner", 32'(winner), 32'b01);

        // 6: reset mid-round and mid-pause
        do_reset();
        check("match_reset_over", 32'(match_over), 32'd0);
        check("match_reset_winner", 32'(winner), 32'd0);
        win_round(1'b1);
        win_round(1'b1);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        check_state("pos2", 9'b000000100, 4'd2, 4'd0);
        do_reset();
        check_state("rst_mid_round", LED_CENTRE, 4'd0, 4'd0);
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
        check("pause_before_rst", 32'(round_over), 32'd1);
        do_reset();
        check_state("rst_in_pause", LED_CENTRE, 4'd0, 4'd0);
        check("rst_in_pause_round_over", 32'(round_over), 32'd0);
        pulse(1'b1, 1'b0);
        check("play_after_rst", 32'(leds), 32'h020);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
